response_framer: RTL



---
 rtl/response_framer_pkg.sv | 40 ++++
 rtl/uart_byte_emitter.sv | 57 +++++
 rtl/response_framer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/response_framer_pkg.sv
// Shared types and helpers for the PUF response framer.
// Optional trailing checksum is enabled with RESPONSE_FRAMER_CHECKSUM_EN.
package response_framer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LEN,
      FETCH,
      LATCH,
      PAYLOAD,
      CSUM,
      FINISH
   } framer_state_t;

   typedef enum logic [1:0] {
      EMIT,
      WAIT_HI,
      WAIT_LO
   } emit_state_t;

   // Widest field the byte-extract helper accepts.
   localparam int MAX_FIELD_BITS = 256;

   function automatic int bytes_per_word(input int word_bits);
      return word_bits / 8;
   endfunction

   function automatic int len_bytes(input int len_bits);
      return len_bits / 8;
   endfunction

   // Byte idx of an nbytes-wide value, counted from the most significant byte.
   function automatic logic [7:0] byte_msb_first(input logic [MAX_FIELD_BITS-1:0] value,
                                                 input int nbytes,
                                                 input int idx);
      return value[(nbytes - 1 - idx) * 8 +: 8];
   endfunction

endpackage

// File: rtl/uart_byte_emitter.sv
// One-byte UART handshake: send when idle, wait for busy to rise and fall, then ack.
// Data is shown combinationally in EMIT and held from a register afterwards.
module uart_byte_emitter
   import response_framer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic [7:0] data,
   output logic       ack,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_enable
);

   emit_state_t state, state_next;
   logic [7:0]  held;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMIT;
         held  <= 8'h00;
      end else begin
         state <= state_next;
         if (state == EMIT && req && !tx_busy)
            held <= data;
      end
   end

   always_comb begin
      state_next = state;
      tx_enable  = 1'b0;
      ack        = 1'b0;
      tx_data    = held;
      unique case (state)
         EMIT: begin
            if (req) begin
               tx_data = data;
               // No send request in a reset cycle; the state is discarded anyway.
               if (!tx_busy && !reset) begin
                  tx_enable  = 1'b1;
                  state_next = WAIT_HI;
               end
            end
         end
         WAIT_HI: if (tx_busy) state_next = WAIT_LO;
         WAIT_LO: begin
            if (!tx_busy) begin
               ack        = 1'b1;
               state_next = EMIT;
            end
         end
         default: state_next = EMIT;
      endcase
   end

endmodule

// File: rtl/response_framer.sv
// Frames NUM_WORDS FIFO words as: ID, length (MSB first), payload (MSB first) [, XOR checksum].
// Define RESPONSE_FRAMER_CHECKSUM_EN to append the checksum byte.
module response_framer
   import response_framer_pkg::*;
#(
   parameter int         WORD_BITS   = 32,
   parameter int         NUM_WORDS   = 1280,
   parameter int         LEN_BITS    = 16,
   parameter logic [7:0] RESPONSE_ID = 8'hAA
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WORD_BITS-1:0] fifo_dout,
   input  logic                 fifo_empty,
   output logic                 fifo_re,
   output logic [7:0]           tx_data,
   output logic                 tx_enable,
   input  logic                 tx_busy,
   output logic                 busy,
   output logic                 done
);

   localparam int BPW     = bytes_per_word(WORD_BITS);
   localparam int LENB    = len_bytes(LEN_BITS);
   localparam int IDX_MAX = (BPW > LENB) ? BPW : LENB;
   localparam int IDX_W   = $clog2(IDX_MAX + 1);

   localparam logic [IDX_W-1:0]    LAST_WORD_IDX = IDX_W'(BPW - 1);
   localparam logic [IDX_W-1:0]    LAST_LEN_IDX  = IDX_W'(LENB - 1);
   localparam logic [LEN_BITS-1:0] NUM_WORDS_L   = LEN_BITS'(NUM_WORDS);

`ifdef RESPONSE_FRAMER_CHECKSUM_EN
   localparam framer_state_t AFTER_PAYLOAD = CSUM;
`else
   localparam framer_state_t AFTER_PAYLOAD = FINISH;
`endif

   framer_state_t        state, state_next;
   logic [LEN_BITS-1:0]  word_cnt;
   logic [IDX_W-1:0]     idx;
   logic [WORD_BITS-1:0] shreg;
   logic                 req;
   logic                 ack;
   logic [7:0]           byte_out;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
   logic [7:0]           csum;
`endif

   uart_byte_emitter u_emit (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .data      (byte_out),
      .ack       (ack),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_enable (tx_enable)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         word_cnt <= '0;
         idx      <= '0;
         shreg    <= '0;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
         csum     <= 8'h00;
`endif
      end else begin
         state <= state_next;
         unique case (state)
            IDLE: begin
               if (start) begin
                  word_cnt <= '0;
                  idx      <= '0;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
                  csum     <= 8'h00;
`endif
               end
            end
            LEN: if (ack) idx <= (idx == LAST_LEN_IDX) ? '0 : idx + 1'b1;
            LATCH: begin
               shreg <= fifo_dout;
               idx   <= '0;
            end
            PAYLOAD: begin
               if (ack) begin
                  shreg <= shreg << 8;
                  if (idx == LAST_WORD_IDX) begin
                     idx      <= '0;
                     word_cnt <= word_cnt + 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
         // Header byte is deliberately left out of the checksum.
         if (ack && (state == LEN || state == PAYLOAD))
            csum <= csum ^ byte_out;
`endif
      end
   end

   always_comb begin
      state_next = state;
      req        = 1'b0;
      byte_out   = 8'h00;
      fifo_re    = 1'b0;
      unique case (state)
         IDLE: if (start) state_next = HDR;
         HDR: begin
            req      = 1'b1;
            byte_out = RESPONSE_ID;
            if (ack) state_next = LEN;
         end
         LEN: begin
            req      = 1'b1;
            byte_out = byte_msb_first(MAX_FIELD_BITS'(NUM_WORDS_L), LENB, int'(idx));
            if (ack && idx == LAST_LEN_IDX) state_next = FETCH;
         end
         FETCH: begin
            if (!fifo_empty) begin
               fifo_re    = !reset;
               state_next = LATCH;
            end
         end
         LATCH: state_next = PAYLOAD;
         PAYLOAD: begin
            req      = 1'b1;
            byte_out = shreg[WORD_BITS-1 -: 8];
            if (ack && idx == LAST_WORD_IDX)
               state_next = (word_cnt + 1'b1 == NUM_WORDS_L) ? AFTER_PAYLOAD : FETCH;
         end
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
         CSUM: begin
            req      = 1'b1;
            byte_out = csum;
            if (ack) state_next = FINISH;
         end
`else
         CSUM: state_next = FINISH;
`endif
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE) && (state != FINISH);
   assign done = (state == FINISH);

endmodule
